i2s_adc_rx: RTL and testbench
=============================

// Module: i2s_adc_rx
// PURPOSE
//  I2S receive deserializer for the codec ADC path. Runs downstream of the BCLK/LRC timing generator on clk_50m.
//  Uses the generator's p_bclk/n_bclk strobes and ADC_LRC to shift in ADCDAT serially.
//  Assembles left/right words into a stereo pair and presents the pair to the analyzer datapath
//  over a valid/ready handshake, with overrun and framing-error reporting.
// PARAMETERS
//  DEPTH      16  bits per channel word, MSB first; must match the timing generator's DEPTH
//  I2S_DELAY  1   p_bclk strobes skipped after each LRC edge before the MSB (1 = Philips I2S, 0 = left-justified)
// PORTS
//  clk_50m      in   1      system clock
//  rst_n        in   1      synchronous, active-low reset
//  p_bclk       in   1      1-clk strobe, BCLK rising edge (sample point)
//  n_bclk       in   1      1-clk strobe, BCLK falling edge
//  adc_lrc      in   1      word clock from generator; 0 = left, 1 = right
//  adcdat       in   1      serial data pad from codec (asynchronous to clk_50m)
//  left_data    out  DEPTH  left sample of held pair
//  right_data   out  DEPTH  right sample of held pair
//  out_valid    out  1      held pair valid
//  out_ready    in   1      consumer accepts pair when out_valid & out_ready
//  overrun      out  1      sticky: a completed pair was dropped
//  ovr_clr      in   1      clears overrun (clear wins over a same-cycle set)
//  frame_err    out  1      1-clk pulse: LRC edge arrived before DEPTH bits were captured
// BEHAVIOUR
//  Reset values
//   - left_data, right_data: 0.
//   - out_valid, overrun, frame_err: 0.
//   - FSM = ALIGN; shift register, bit counter and synchronizer flops cleared.
//  Input capture
//   - adcdat passes through a 2-FF synchronizer.
//   - Data is sampled only on p_bclk cycles, using the synchronizer output.
//   - Codec launches on n_bclk, about half a BCLK period earlier, so the 2-clk sync delay is safe.
//  LRC edge detection
//   - lrc_q registered every clk; edge = adc_lrc ^ lrc_q.
//   - Falling edge (1->0) starts the left word; rising edge starts the right word.
//  FSM
//   - ALIGN: ignore all data until the first LRC falling edge, then -> SKIP with ch=L.
//     A pair is never built from a partial frame.
//   - SKIP: count I2S_DELAY p_bclk strobes, then -> SHIFT. With I2S_DELAY=0, go straight to SHIFT.
//   - SHIFT: on each p_bclk, sr <= {sr[DEPTH-2:0], din} and bit_cnt++.
//     - After the DEPTH-th bit: latch sr into the left or right holding register.
//     - Then -> PAD.
//   - PAD: ignore bits until the next LRC edge, then toggle ch and -> SKIP.
//   - LRC edge in SKIP or SHIFT (short word): pulse frame_err, discard the partial pair, -> ALIGN.
//     - Exception: an LRC falling edge here goes directly to SKIP with ch=L.
//   - LRC edge has priority over a same-cycle p_bclk.
//  Pair output
//   - Right word complete (left already held): pair_done asserts for one clk.
//   - On the next clk:
//     - if slot free (!out_valid) or being accepted this cycle (out_valid & out_ready):
//       left_data/right_data load and out_valid=1;
//     - otherwise the new pair is dropped, the output is unchanged, and overrun <= 1.
//   - Latency: out_valid rises 2 clk after the p_bclk carrying the right LSB.
//   - Handshake:
//     - out_valid stays high and data stays stable until out_ready is sampled high.
//     - out_valid drops the next clk unless a new pair loads in the same cycle.
//  Reset mid-frame: state is lost; the block re-aligns on the next LRC falling edge.
//  Widths: bit_cnt is $clog2(DEPTH+1) bits and never wraps; it is cleared on entry to SKIP.
// TESTING (DEPTH=16, I2S_DELAY=1, driven by the timing generator, 19 BCLK per channel)
//  1. Codec model sends L=16'hA5C3, R=16'h1234, out_ready=1
//     -> one out_valid pulse; left_data=A5C3, right_data=1234; no frame_err.
//  2. out_ready=0 for 3 frames (L/R = 0001/0002, 0003/0004, 0005/0006)
//     -> outputs hold 0001/0002; overrun=1 after frame 2; ovr_clr pulse -> overrun=0.
//  3. rst_n low for 10 clk in the middle of a right word
//     -> no out_valid until one full L+R after the next LRC falling edge; first pair correct.
//  4. Force an LRC edge after 10 bits of a left word
//     -> one frame_err pulse; no out_valid for that frame; next full frame decodes correctly.
//  5. out_ready toggling, with a pair arriving in the same clk as acceptance
//     -> new pair loads, out_valid stays 1, overrun stays 0.
//  6. Random 200-frame stream, out_ready=1
//     -> every pair matches the scoreboard; exactly one out_valid per LRC period; zero errors.

Source files
------------

// File: rtl/i2s_adc_rx.sv
// I2S ADC receive path: deserializes ADCDAT on p_bclk strobes, frames words by ADC_LRC,
// and presents left/right pairs downstream over valid/ready with overrun and framing-error flags.

module i2s_adc_rx #(
  parameter int DEPTH     = 16,
  parameter int I2S_DELAY = 1
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             p_bclk,
  input  logic             n_bclk,
  input  logic             adc_lrc,
  input  logic             adcdat,
  output logic [DEPTH-1:0] left_data,
  output logic [DEPTH-1:0] right_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             frame_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(I2S_DELAY + 1) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DEPTH - 1);
  localparam logic [SW-1:0] SKIP_LAST = SW'((I2S_DELAY > 0) ? I2S_DELAY - 1 : 0);
  localparam logic          CH_L      = 1'b0;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } state_e;

  localparam state_e START_ST = (I2S_DELAY == 0) ? ST_SHIFT : ST_SKIP;

  logic             din_meta_q, din_sync_q, lrc_q;
  logic             lrc_edge_s, lrc_fall_s;
  state_e           state_q, state_d;
  logic             ch_q, ch_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]    skip_cnt_q, skip_cnt_d;
  logic [DEPTH-1:0] sr_q, sr_d, sr_shift_s;
  logic [DEPTH-1:0] left_hold_q, left_hold_d;
  logic [DEPTH-1:0] right_hold_q, right_hold_d;
  logic             have_left_q, have_left_d;
  logic             pair_done_q, pair_done_d;
  logic             frame_err_q, frame_err_d;
  logic [DEPTH-1:0] left_data_q, left_data_d;
  logic [DEPTH-1:0] right_data_q, right_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             overrun_set_s;
  logic             unused_n_bclk_s;

  // The codec launches on n_bclk; sampling only needs the p_bclk strobe.
  assign unused_n_bclk_s = n_bclk;

  assign lrc_edge_s = adc_lrc ^ lrc_q;
  assign lrc_fall_s = lrc_edge_s & ~adc_lrc;
  assign sr_shift_s = {sr_q[DEPTH-2:0], din_sync_q};

  // Data-pad synchronizer and LRC history
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      din_meta_q <= 1'b0;
      din_sync_q <= 1'b0;
      lrc_q      <= 1'b0;
    end else begin
      din_meta_q <= adcdat;
      din_sync_q <= din_meta_q;
      lrc_q      <= adc_lrc;
    end
  end

  // Framing state and word assembly registers
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q      <= ST_ALIGN;
      ch_q         <= CH_L;
      bit_cnt_q    <= {CW{1'b0}};
      skip_cnt_q   <= {SW{1'b0}};
      sr_q         <= {DEPTH{1'b0}};
      left_hold_q  <= {DEPTH{1'b0}};
      right_hold_q <= {DEPTH{1'b0}};
      have_left_q  <= 1'b0;
      pair_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      bit_cnt_q    <= bit_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      sr_q         <= sr_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      have_left_q  <= have_left_d;
      pair_done_q  <= pair_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state logic; an LRC edge always outranks a same-cycle p_bclk
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    bit_cnt_d    = bit_cnt_q;
    skip_cnt_d   = skip_cnt_q;
    sr_d         = sr_q;
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    have_left_d  = have_left_q;
    pair_done_d  = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        if (lrc_fall_s) begin
          state_d    = START_ST;
          ch_d       = CH_L;
          bit_cnt_d  = {CW{1'b0}};
          skip_cnt_d = {SW{1'b0}};
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_SKIP, ST_SHIFT: begin
        if (lrc_edge_s) begin
          frame_err_d = 1'b1;
          have_left_d = 1'b0;
          if (lrc_fall_s) begin
            state_d    = START_ST;
            ch_d       = CH_L;
            bit_cnt_d  = {CW{1'b0}};
            skip_cnt_d = {SW{1'b0}};
          end else begin
            state_d = ST_ALIGN;
          end
        end else if (!p_bclk) begin
          state_d = state_q;
        end else if (state_q == ST_SKIP) begin
          if (skip_cnt_q == SKIP_LAST) begin
            state_d = ST_SHIFT;
          end else begin
            skip_cnt_d = skip_cnt_q + SW'(1);
          end
        end else begin
          sr_d      = sr_shift_s;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_PAD;
            if (ch_q == CH_L) begin
              left_hold_d = sr_shift_s;
              have_left_d = 1'b1;
            end else if (have_left_q) begin
              right_hold_d = sr_shift_s;
              pair_done_d  = 1'b1;
              have_left_d  = 1'b0;
            end else begin
              have_left_d = 1'b0;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_PAD: begin
        if (lrc_edge_s) begin
          state_d    = START_ST;
          ch_d       = ~ch_q;
          bit_cnt_d  = {CW{1'b0}};
          skip_cnt_d = {SW{1'b0}};
        end else begin
          state_d = ST_PAD;
        end
      end
      default: begin
        state_d = ST_ALIGN;
      end
    endcase
  end

  // Output slot: a completed pair loads if the slot is free or being emptied this cycle
  always_comb begin
    out_valid_d   = out_valid_q;
    left_data_d   = left_data_q;
    right_data_d  = right_data_q;
    overrun_set_s = 1'b0;
    if (pair_done_q) begin
      if (!out_valid_q || out_ready) begin
        left_data_d  = left_hold_q;
        right_data_d = right_hold_q;
        out_valid_d  = 1'b1;
      end else begin
        overrun_set_s = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end else if (overrun_set_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Output pair, handshake and overrun registers
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      left_data_q  <= {DEPTH{1'b0}};
      right_data_q <= {DEPTH{1'b0}};
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: a BCLK/LRC generator plus codec model drives the serial side,
// and a channel-level pair model predicts which stereo pairs must reach the output.

module tb_i2s_adc_rx;

  localparam int DEPTH    = 16;
  localparam int SLOTS    = 19;
  localparam int BCLK_DIV = 8;

  logic             clk_50m = 1'b0;
  logic             rst_n = 1'b0;
  logic             p_bclk = 1'b0;
  logic             n_bclk = 1'b0;
  logic             adc_lrc = 1'b0;
  logic             adcdat = 1'b0;
  logic             out_ready = 1'b0;
  logic             ovr_clr = 1'b0;
  logic [DEPTH-1:0] left_data, right_data;
  logic             out_valid, overrun, frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vrise    = 0;
  int ferr_cnt = 0;
  int rise_cyc = 0;
  int lsb_cyc  = 0;
  int pulse_sel = 0;
  logic prev_v = 1'b0;
  logic [31:0] acc_q[$];
  logic [31:0] prod_q[$];
  logic        m_aligned = 1'b0;
  logic        m_have_l  = 1'b0;
  logic [15:0] m_left    = 16'h0;

  i2s_adc_rx #(.DEPTH(DEPTH), .I2S_DELAY(1)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .p_bclk(p_bclk), .n_bclk(n_bclk),
    .adc_lrc(adc_lrc), .adcdat(adcdat), .left_data(left_data), .right_data(right_data),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun), .ovr_clr(ovr_clr),
    .frame_err(frame_err)
  );

  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Observe outputs mid-cycle: valid rises, frame_err pulses, accepted pairs
  initial forever begin
    @(negedge clk_50m);
    #1;
    if (rst_n) begin
      if (out_valid && !prev_v) begin
        vrise++;
        rise_cyc = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (out_valid && out_ready) acc_q.push_back({left_data, right_data});
    end
    prev_v = out_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    got = {32{1'bx}};
    if (acc_q.size() > 0) got = acc_q.pop_front();
    check(tag, got, exp);
  endtask

  // One BCLK period: codec drives on n_bclk (with any LRC change), DUT samples on p_bclk
  task automatic bclk_slot(input logic lrc, input logic d, input bit is_lsb);
    for (int c = 0; c < BCLK_DIV; c++) begin
      @(negedge clk_50m);
      n_bclk = (c == 0);
      p_bclk = (c == BCLK_DIV / 2);
      if (c == 0) begin
        adc_lrc = lrc;
        adcdat  = d;
      end
      if (is_lsb && c == BCLK_DIV / 2) lsb_cyc = cyc;
      if (is_lsb && c == BCLK_DIV / 2 + 1) begin
        if (pulse_sel == 1) out_ready = 1'b1;
        else if (pulse_sel == 2) ovr_clr = 1'b1;
      end
      if (is_lsb && c == BCLK_DIV / 2 + 2) begin
        if (pulse_sel == 1) out_ready = 1'b0;
        else if (pulse_sel == 2) ovr_clr = 1'b0;
      end
    end
  endtask

  // One channel: delay slot, nbits data MSB first, pad only for a full word
  task automatic send_chan(input logic lrc, input logic [15:0] word, input int nbits);
    int nslots;
    logic d;
    nslots = (nbits == DEPTH) ? SLOTS : nbits + 1;
    if (lrc == 1'b0) begin
      m_aligned = 1'b1;
      m_have_l  = 1'b0;
    end
    for (int s = 0; s < nslots; s++) begin
      if (s >= 1 && s <= nbits) d = word[DEPTH - s];
      else d = 1'($urandom_range(1, 0));
      bclk_slot(lrc, d, lrc && (s == DEPTH));
    end
    if (nbits < DEPTH) begin
      m_aligned = 1'b0;
      m_have_l  = 1'b0;
    end else if (m_aligned) begin
      if (lrc == 1'b0) begin
        m_left   = word;
        m_have_l = 1'b1;
      end else begin
        if (m_have_l) prod_q.push_back({m_left, word});
        m_have_l = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_chan(1'b0, l, DEPTH);
    send_chan(1'b1, r, DEPTH);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_50m);
    rst_n = 1'b0;
    repeat (n) @(negedge clk_50m);
    rst_n = 1'b1;
    m_aligned = 1'b0;
    m_have_l  = 1'b0;
  endtask

  initial begin
    int v0, f0, vb;
    logic [15:0] la, ra, lb, rb;

    // Reset values
    repeat (4) @(negedge clk_50m);
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_left", 32'(left_data), 32'd0);
    check("rst_right", 32'(right_data), 32'd0);
    rst_n = 1'b1;

    // Single frame, consumer always ready
    out_ready = 1'b1;
    send_chan(1'b1, 16'($urandom), DEPTH);
    v0 = vrise; f0 = ferr_cnt;
    send_frame(16'hA5C3, 16'h1234);
    #2;
    check("t1_valid_pulses", 32'(vrise - v0), 32'd1);
    check_pair("t1_pair", 32'hA5C3_1234);
    check("t1_left_reg", 32'(left_data), 32'h0000_A5C3);
    check("t1_right_reg", 32'(right_data), 32'h0000_1234);
    check("t1_latency", 32'(rise_cyc - lsb_cyc), 32'd2);
    check("t1_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("t1_valid_dropped", 32'(out_valid), 32'd0);
    prod_q.delete();

    // Stalled consumer: hold, overrun, clear, clear-wins-over-set
    out_ready = 1'b0;
    send_frame(16'h0001, 16'h0002);
    #2;
    check("t2_hold_valid", 32'(out_valid), 32'd1);
    check("t2_hold_left", 32'(left_data), 32'h0000_0001);
    check("t2_hold_right", 32'(right_data), 32'h0000_0002);
    check("t2_no_overrun_yet", 32'(overrun), 32'd0);
    send_frame(16'h0003, 16'h0004);
    #2;
    check("t2_overrun_set", 32'(overrun), 32'd1);
    check("t2_left_kept", 32'(left_data), 32'h0000_0001);
    send_frame(16'h0005, 16'h0006);
    #2;
    check("t2_right_kept", 32'(right_data), 32'h0000_0002);
    check("t2_overrun_sticky", 32'(overrun), 32'd1);
    @(negedge clk_50m) ovr_clr = 1'b1;
    @(negedge clk_50m) ovr_clr = 1'b0;
    #2;
    check("t2_overrun_cleared", 32'(overrun), 32'd0);
    pulse_sel = 2;
    send_frame(16'h0007, 16'h0008);
    pulse_sel = 0;
    #2;
    check("t2_clear_wins", 32'(overrun), 32'd0);
    check("t2_left_still", 32'(left_data), 32'h0000_0001);
    @(negedge clk_50m) out_ready = 1'b1;
    @(negedge clk_50m) out_ready = 1'b0;
    #2;
    check_pair("t2_accepted", 32'h0001_0002);
    check("t2_valid_after_accept", 32'(out_valid), 32'd0);
    check("t2_single_accept", 32'(acc_q.size()), 32'd0);
    prod_q.delete();

    // Reset in the middle of a right word
    out_ready = 1'b1;
    v0 = vrise; f0 = ferr_cnt;
    send_chan(1'b0, 16'hBEEF, DEPTH);
    for (int s = 0; s < 8; s++) bclk_slot(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    do_reset(10);
    for (int s = 8; s < SLOTS; s++) bclk_slot(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    #2;
    check("t3_no_valid_partial", 32'(vrise - v0), 32'd0);
    check("t3_left_reset", 32'(left_data), 32'd0);
    la = 16'($urandom); ra = 16'($urandom);
    send_frame(la, ra);
    #2;
    check("t3_one_valid", 32'(vrise - v0), 32'd1);
    check_pair("t3_first_pair", {la, ra});
    check("t3_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    prod_q.delete();

    // Short left word: framing error, frame discarded, recovery
    v0 = vrise; f0 = ferr_cnt;
    send_chan(1'b0, 16'hCAFE, 10);
    send_chan(1'b1, 16'h5555, DEPTH);
    #2;
    check("t4_frame_err", 32'(ferr_cnt - f0), 32'd1);
    check("t4_no_valid", 32'(vrise - v0), 32'd0);
    la = 16'($urandom); ra = 16'($urandom);
    send_frame(la, ra);
    #2;
    check("t4_recover_valid", 32'(vrise - v0), 32'd1);
    check("t4_model_count", 32'(prod_q.size()), 32'd1);
    check_pair("t4_recover_pair", {la, ra});
    check("t4_single_err", 32'(ferr_cnt - f0), 32'd1);
    prod_q.delete();

    // New pair arrives in the same clk the held pair is accepted
    out_ready = 1'b0;
    v0 = vrise;
    la = 16'($urandom); ra = 16'($urandom);
    lb = 16'($urandom); rb = 16'($urandom);
    send_frame(la, ra);
    #2;
    check("t5_held_left", 32'(left_data), 32'(la));
    pulse_sel = 1;
    send_frame(lb, rb);
    pulse_sel = 0;
    #2;
    check("t5_valid_stays", 32'(out_valid), 32'd1);
    check("t5_new_left", 32'(left_data), 32'(lb));
    check("t5_new_right", 32'(right_data), 32'(rb));
    check("t5_no_overrun", 32'(overrun), 32'd0);
    check("t5_one_rise", 32'(vrise - v0), 32'd1);
    check_pair("t5_first_accepted", {la, ra});
    @(negedge clk_50m) out_ready = 1'b1;
    @(negedge clk_50m) out_ready = 1'b0;
    @(negedge clk_50m) out_ready = 1'b1;
    @(negedge clk_50m) out_ready = 1'b0;
    #2;
    check_pair("t5_second_accepted", {lb, rb});
    check("t5_valid_done", 32'(out_valid), 32'd0);
    prod_q.delete();
    acc_q.delete();

    // Random stream against the pair model
    out_ready = 1'b1;
    v0 = vrise; f0 = ferr_cnt;
    for (int i = 0; i < 200; i++) begin
      vb = vrise;
      send_frame(16'($urandom), 16'($urandom));
      check("t6_one_valid_per_frame", 32'(vrise - vb), 32'd1);
    end
    #2;
    check("t6_pair_count", 32'(acc_q.size()), 32'(prod_q.size()));
    check("t6_model_count", 32'(prod_q.size()), 32'd200);
    while (prod_q.size() > 0) check_pair("t6_pair", prod_q.pop_front());
    check("t6_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("t6_no_overrun", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
